// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the forwarding/hazard unit: default widths, the hard-wired zero
// register and the bit layout of a tracking entry {v, dest, ld}.
package fwd_hazard_unit_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    // Entry layout, LSB first: ld, dest[ADDR_W-1:0], v
    localparam int ENT_LD   = 0;
    localparam int ENT_DEST = 1;

    function automatic int ent_v(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int ent_w(input int addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/fwd_src_mux.sv
// Per-source forwarding select: picks the youngest in-flight write to this source
// register, or flags a load-use hazard when that write is a load whose data is not ready.
module fwd_src_mux
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NSTAGES    = 3,
    parameter int LOAD_AVAIL = 1
) (
    input  logic [NSTAGES*(ADDR_W+2)-1:0] ents,
    input  logic [NSTAGES*DATA_W-1:0]     stg_wbvalue,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             data,
    output logic [DATA_W-1:0]             fw_data,
    output logic                          hazard
);

    localparam int EW = ent_w(ADDR_W);
    localparam int EV = ent_v(ADDR_W);

    logic found;

    // Lowest index is youngest; once found, older matches are ignored even if usable.
    always_comb begin
        found   = 1'b0;
        fw_data = data;
        hazard  = 1'b0;
        if (addr == ADDR_W'(REG_ZERO)) begin
            fw_data = '0;
        end else begin
            for (int i = 0; i < NSTAGES; i++) begin
                if (!found && ents[i*EW + EV] &&
                    (ents[i*EW + ENT_DEST +: ADDR_W] == addr)) begin
                    found = 1'b1;
                    if (ents[i*EW + ENT_LD] && (i < LOAD_AVAIL))
                        hazard = 1'b1;
                    else
                        fw_data = stg_wbvalue[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight register writes in a shift
// register, forwards the youngest result per source and stalls on unready loads.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NSRC       = 2,
    parameter int NSTAGES    = 3,
    parameter int LOAD_AVAIL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic                      id_writereg,
    input  logic [ADDR_W-1:0]         id_regdest,
    input  logic                      id_load,
    input  logic [NSRC*ADDR_W-1:0]    id_addr,
    input  logic [NSRC*DATA_W-1:0]    id_data,
    input  logic [NSTAGES*DATA_W-1:0] stg_wbvalue,
    input  logic                      ex_stall,
    output logic [NSRC*DATA_W-1:0]    fw_data,
    output logic                      fw_stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int EW = ent_w(ADDR_W);

    logic [EW-1:0]           ent [NSTAGES];
    logic [NSTAGES*EW-1:0]   ent_flat;
    logic [NSRC-1:0]         hazard;
    logic [EW-1:0]           ent_new;
    logic                    writes_reg;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    for (genvar i = 0; i < NSTAGES; i++) begin : g_flat
        assign ent_flat[i*EW +: EW] = ent[i];
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        fwd_src_mux #(
            .DATA_W     (DATA_W),
            .ADDR_W     (ADDR_W),
            .NSTAGES    (NSTAGES),
            .LOAD_AVAIL (LOAD_AVAIL)
        ) u_mux (
            .ents        (ent_flat),
            .stg_wbvalue (stg_wbvalue),
            .addr        (id_addr[s*ADDR_W +: ADDR_W]),
            .data        (id_data[s*DATA_W +: DATA_W]),
            .fw_data     (fw_data[s*DATA_W +: DATA_W]),
            .hazard      (hazard[s])
        );
    end

    // Gating with reset keeps the stall quiet while the async clear is in effect.
    assign fw_stall   = id_valid & (|hazard) & ~reset;
    assign writes_reg = id_valid & id_writereg & (id_regdest != ADDR_W'(REG_ZERO));
    assign ent_new    = fw_stall ? '0 : {writes_reg, id_regdest, id_load};

    // Tracking stage boundary: decode -> EX and down the forwarding stages
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSTAGES; i++) ent[i] <= '0;
            stall_cnt <= '0;
        end else if (!ex_stall) begin
            for (int i = 1; i < NSTAGES; i++) ent[i] <= ent[i-1];
            ent[0] <= ent_new;
            if (fw_stall) stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule
